// File: rtl/qa_7seg_display_ctrl.sv
// qa_7seg_display_ctrl: registered multi-digit 7-segment display controller.
// Holds a DIGITS-wide nibble register, loaded in parallel or shifted in one
// nibble at a time, and drives registered per-digit segment outputs. The
// digit outputs support per-digit enable, leading-zero blanking and blink.
//
// Optional feature macro: QA_7SEG_BLINK_EN. When it is defined, the blink
// counter, the blink phase and the blinkMaskIn gating are built. When it is
// undefined, blinkMaskIn is ignored and digits never blink.
//
// Ports:
//   clockIn        system clock, rising edge
//   nResetIn       asynchronous active-low reset
//   loadIn         parallel load strobe (has priority over shiftIn)
//   dataIn         parallel nibbles, digit i = dataIn[4i+3:4i]
//   shiftIn        shift strobe, nibbleIn enters digit 0
//   nibbleIn       nibble shifted into digit 0
//   digitEnableIn  1 = digit may light
//   blinkMaskIn    1 = digit blinks
//   lzbIn          leading-zero blanking enable
//   displayDataOut current nibble register
//   segmentsOut    digit i = segmentsOut[7i+6:7i], bit0 = a .. bit6 = g
module qa_7seg_display_ctrl #(
   parameter int unsigned DIGITS     = 6,
   parameter int unsigned BLINK_DIV  = 25000000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                  clockIn,
   input  logic                  nResetIn,
   input  logic                  loadIn,
   input  logic [4*DIGITS-1:0]   dataIn,
   input  logic                  shiftIn,
   input  logic [3:0]            nibbleIn,
   input  logic [DIGITS-1:0]     digitEnableIn,
   input  logic [DIGITS-1:0]     blinkMaskIn,
   input  logic                  lzbIn,
   output logic [4*DIGITS-1:0]   displayDataOut,
   output logic [7*DIGITS-1:0]   segmentsOut
);

   localparam int unsigned DW = 4 * DIGITS;
   localparam int unsigned SW = 7 * DIGITS;
   localparam logic [6:0]  SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [DW-1:0]     r_nibbles;
   logic [DW-1:0]     w_shifted;
   logic [SW-1:0]     r_segments;
   logic [SW-1:0]     w_seg_next;
   logic [DIGITS-1:0] w_lead_zero;
   logic [DIGITS-1:0] w_blink_off;

   // Active-high hex decode, bit0 = a .. bit6 = g.
   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Shift path: new nibble enters digit 0, the top digit falls off.
   generate
      if (DIGITS == 1) begin : g_shift_one
         assign w_shifted = nibbleIn;
      end else begin : g_shift_many
         assign w_shifted = {r_nibbles[DW-5:0], nibbleIn};
      end
   endgenerate

   // Nibble register: load beats shift, otherwise hold.
   always_ff @(posedge clockIn or negedge nResetIn) begin
      if (!nResetIn) begin
         r_nibbles <= '0;
      end else if (loadIn) begin
         r_nibbles <= dataIn;
      end else if (shiftIn) begin
         r_nibbles <= w_shifted;
      end
   end

`ifdef QA_7SEG_BLINK_EN
   localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] r_blink_cnt;
   logic          r_blink_phase;

   // Free-running blink divider; phase toggles on each wrap.
   always_ff @(posedge clockIn or negedge nResetIn) begin
      if (!nResetIn) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == CW'(BLINK_DIV - 1)) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt   <= r_blink_cnt + CW'(1);
      end
   end

   assign w_blink_off = blinkMaskIn & {DIGITS{r_blink_phase}};
`else
   localparam int unsigned blink_div_unused = BLINK_DIV;
   logic w_unused_mask;

   assign w_unused_mask = ^blinkMaskIn;
   assign w_blink_off   = '0;
`endif

   // w_lead_zero[i] = nibbles i..DIGITS-1 are all zero.
   always_comb begin
      logic v_zero;
      v_zero      = 1'b1;
      w_lead_zero = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_zero         = v_zero & (r_nibbles[4*i +: 4] == 4'h0);
         w_lead_zero[i] = v_zero;
      end
   end

   // Per-digit decode with blanking; polarity applied last.
   always_comb begin
      logic       v_blank;
      logic [6:0] v_seg;
      w_seg_next = '0;
      for (int i = 0; i < DIGITS; i++) begin
         v_blank = ~digitEnableIn[i] | w_blink_off[i];
         if (i != 0) begin
            v_blank = v_blank | (lzbIn & w_lead_zero[i]);
         end
         v_seg = hex_decode(r_nibbles[4*i +: 4]);
         if (v_blank) begin
            w_seg_next[7*i +: 7] = SEG_OFF;
         end else if (ACTIVE_LOW) begin
            w_seg_next[7*i +: 7] = ~v_seg;
         end else begin
            w_seg_next[7*i +: 7] = v_seg;
         end
      end
   end

   // Registered segment outputs; reset shows every segment off.
   always_ff @(posedge clockIn or negedge nResetIn) begin
      if (!nResetIn) begin
         r_segments <= {DIGITS{SEG_OFF}};
      end else begin
         r_segments <= w_seg_next;
      end
   end

   assign displayDataOut = r_nibbles;
   assign segmentsOut    = r_segments;

endmodule

// File: tb/tb_qa_7seg_display_ctrl.sv
// Scoreboard bench for qa_7seg_display_ctrl (DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1).
module tb_qa_7seg_display_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        loadIn = 1'b0;
   logic [23:0] dataIn = '0;
   logic        shiftIn = 1'b0;
   logic [3:0]  nibbleIn = '0;
   logic [5:0]  digitEnableIn = 6'h3F;
   logic [5:0]  blinkMaskIn = '0;
   logic        lzbIn = 1'b0;
   logic [23:0] displayDataOut;
   logic [41:0] segmentsOut;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc;

   typedef struct {
      int          cyc;
      bit          is_seg;
      logic [41:0] exp;
      string       name;
   } sb_item_t;

   sb_item_t sb[$];

   qa_7seg_display_ctrl #(
      .DIGITS     (6),
      .BLINK_DIV  (4),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clockIn        (clk),
      .nResetIn       (rst_n),
      .loadIn         (loadIn),
      .dataIn         (dataIn),
      .shiftIn        (shiftIn),
      .nibbleIn       (nibbleIn),
      .digitEnableIn  (digitEnableIn),
      .blinkMaskIn    (blinkMaskIn),
      .lzbIn          (lzbIn),
      .displayDataOut (displayDataOut),
      .segmentsOut    (segmentsOut)
   );

   always #5 clk = ~clk;

   // Edges since the last reset release: after edge n, cyc == n.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [41:0] segs(input logic [6:0] d5, d4, d3, d2, d1, d0);
      return {d5, d4, d3, d2, d1, d0};
   endfunction

   // Segments after edge n sample the phase held before that edge.
   function automatic logic [6:0] blink_digit0(input int n);
`ifdef QA_7SEG_BLINK_EN
      return ((((n - 1) / 4) % 2) == 0) ? 7'h40 : 7'h7F;
`else
      return 7'h40;
`endif
   endfunction

   task automatic expect_at(input int at, input bit is_seg, input logic [41:0] exp, input string name);
      sb_item_t it;
      it.cyc = at; it.is_seg = is_seg; it.exp = exp; it.name = name;
      sb.push_back(it);
   endtask

   // Monitor: compare every queued expectation due at this edge count.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               if (sb[i].is_seg) check({sb[i].name, "_seg"}, segmentsOut, sb[i].exp);
               else              check({sb[i].name, "_data"}, 42'(displayDataOut), sb[i].exp);
               sb.delete(i);
            end
         end
      end
   end

   // Drive one strobe cycle, then hold enables for the segment update cycle.
   task automatic step(input string name, input logic ld, input logic sh,
                       input logic [23:0] d, input logic [3:0] nib,
                       input logic [5:0] en, input logic [5:0] mk, input logic lz,
                       input logic [23:0] exp_d, input bit chk_seg, input logic [41:0] exp_s);
      @(posedge clk); #2;
      loadIn = ld; shiftIn = sh; dataIn = d; nibbleIn = nib;
      digitEnableIn = en; blinkMaskIn = mk; lzbIn = lz;
      expect_at(cyc + 1, 1'b0, 42'(exp_d), name);
      if (chk_seg) expect_at(cyc + 2, 1'b1, exp_s, name);
      @(posedge clk); #2;
      loadIn = 1'b0; shiftIn = 1'b0;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("reset_seg", segmentsOut, 42'h3FFFFFFFFFF);
      check("reset_data", 42'(displayDataOut), 42'h0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      expect_at(1, 1'b0, 42'h0, "post_reset");
      expect_at(1, 1'b1, segs(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), "post_reset");

      step("load", 1, 0, 24'h12AB0F, 4'h0, 6'h3F, 6'h00, 0, 24'h12AB0F, 1,
           segs(7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E));
      step("load0", 1, 0, 24'h000000, 4'h0, 6'h3F, 6'h00, 0, 24'h000000, 1,
           segs(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40));
      step("shift1", 0, 1, 24'h000000, 4'h1, 6'h3F, 6'h00, 0, 24'h000001, 0, '0);
      step("shift2", 0, 1, 24'h000000, 4'h2, 6'h3F, 6'h00, 0, 24'h000012, 0, '0);
      step("shift3", 0, 1, 24'h000000, 4'h3, 6'h3F, 6'h00, 0, 24'h000123, 1,
           segs(7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30));
      step("load_wins", 1, 1, 24'hFFFFFF, 4'h5, 6'h3F, 6'h00, 0, 24'hFFFFFF, 1,
           segs(7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E));
      step("lzb_120", 1, 0, 24'h000120, 4'h0, 6'h3F, 6'h00, 1, 24'h000120, 1,
           segs(7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40));
      step("lzb_zero", 1, 0, 24'h000000, 4'h0, 6'h3F, 6'h00, 1, 24'h000000, 1,
           segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40));
      step("lzb_en1", 1, 0, 24'h000120, 4'h0, 6'h3D, 6'h00, 1, 24'h000120, 1,
           segs(7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h7F, 7'h40));
      step("hold", 0, 0, 24'hABCDEF, 4'h7, 6'h3F, 6'h00, 0, 24'h000120, 1,
           segs(7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40));

      // Blink on digit 0 with data 0; other digits stay lit.
      step("blink_load", 1, 0, 24'h000000, 4'h0, 6'h3F, 6'h01, 0, 24'h000000, 0, '0);
      for (int n = cyc + 1; n <= cyc + 16; n++)
         expect_at(n, 1'b1, segs(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, blink_digit0(n)), "blink");
      repeat (17) @(posedge clk);

      // Asynchronous reset between edges while showing 123456.
      step("pre_rst", 1, 0, 24'h123456, 4'h0, 6'h3F, 6'h01, 0, 24'h123456, 0, '0);
      @(posedge clk); #2;
      check("queue_drained", 42'(sb.size()), 42'h0);
      rst_n = 1'b0;
      #1;
      check("async_rst_seg", segmentsOut, 42'h3FFFFFFFFFF);
      check("async_rst_data", 42'(displayDataOut), 42'h0);
      @(negedge clk); rst_n = 1'b1;
      expect_at(1, 1'b0, 42'h0, "rst_release");
      for (int n = 1; n <= 8; n++)
         expect_at(n, 1'b1, segs(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, blink_digit0(n)), "rst_blink");
      repeat (10) @(posedge clk);
      #2;
      check("queue_empty", 42'(sb.size()), 42'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
